trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of trace entries stored; power of two, minimum 2.
REQ-002 SHALL have parameter DROP_W, default 16: width of the drop counter.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port trace_ready_i, input, 1: one-cycle push strobe from trace_unit.
REQ-006 SHALL have port trace_i, input, trace_output: trace record, valid when trace_ready_i=1.
REQ-007 SHALL have port flush_i, input, 1: synchronous discard of all stored entries.
REQ-008 SHALL have port out_valid_o, output, 1: head entry available.
REQ-009 SHALL have port out_ready_i, input, 1: consumer accepts head; pop when out_valid_o & out_ready_i.
REQ-010 SHALL have port out_data_o, output, trace_output: head record.
REQ-011 SHALL have port out_gap_o, output, 1: head entry was preceded by one or more dropped records.
REQ-012 SHALL have port count_o, output, $clog2(DEPTH)+1: current occupancy.
REQ-013 SHALL have port drop_count_o, output, DROP_W: total records dropped since reset.

Function
REQ-014 SHALL implement a show-ahead FIFO; out_data_o/out_gap_o reflect the head entry combinationally from storage.
REQ-015 SHALL assert out_valid_o iff count_o != 0.
REQ-016 Push into an empty buffer SHALL appear on out_valid_o the cycle after trace_ready_i (1-cycle latency).
REQ-017 Read/write pointers SHALL be $clog2(DEPTH)+1 bits with an extra wrap bit; full = MSBs differ and the remaining bits are equal; empty = pointers equal.
REQ-018 There is no backpressure to the tracer; a push while full with no simultaneous pop SHALL be dropped.
REQ-019 On a drop, drop_count_o SHALL increment by 1, saturating at all-ones, and an internal gap_pending flag SHALL be set.
REQ-020 The next accepted push SHALL store gap=1 with its record and clear gap_pending; otherwise gap=0 is stored.
REQ-021 Simultaneous push and pop while full SHALL accept the push; count is unchanged and there is no drop.
REQ-022 Simultaneous push and pop while non-empty SHALL leave count unchanged.
REQ-023 out_ready_i while empty SHALL have no effect.
REQ-024 flush_i SHALL empty the buffer and clear gap_pending next cycle; drop_count_o SHALL be retained.
REQ-025 flush_i SHALL take priority over a same-cycle push or pop; the push is discarded and not counted as a drop.
REQ-026 out_data_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.

Reset
REQ-027 rst_i=1 SHALL clear pointers, gap_pending and drop_count and the timestamp counter, giving out_valid_o=0, count_o=0, drop_count_o=0 and out_gap_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries; push/pop in the reset cycle SHALL be ignored.
REQ-029 Storage array contents need not be reset.

Configuration
REQ-030 Macro TRACE_BUFFER_TIMESTAMP_EN defined: SHALL add port out_timestamp_o, output, 32, and a free-running 32-bit cycle counter (wraps at 2^32-1 to 0, reset to 0).
REQ-031 With the macro defined, the counter value in the push cycle SHALL be stored with each accepted entry and presented with the head.
REQ-032 Macro undefined: no port, counter or storage for the timestamp; all other behaviour is identical.

Structure
REQ-033 Type trace_buffer_entry (trace_output record, gap bit, optional timestamp) SHALL be defined in package ryuki_datatypes.
REQ-034 Default DEPTH and DROP_W constants SHALL be defined in package ryuki_datatypes.
REQ-035 Pointer/storage logic SHALL be a sub-module trace_fifo, parameterised by entry type and DEPTH; drop/gap/timestamp logic stays in trace_buffer.

Verification (DEPTH=4)
REQ-036 Reset, then one push of record A with out_ready_i=0 -> out_valid_o=1 next cycle, out_data_o=A, count_o=1, out_gap_o=0.
REQ-037 6 back-to-back pushes A..F with out_ready_i=0 -> count_o=4, drop_count_o=2; pop yields A,B,C,D; then push G -> G read with out_gap_o=1.
REQ-038 Full buffer, push and pop in the same cycle -> count_o stays 4, drop_count_o unchanged, new record is last out.
REQ-039 3 entries, flush_i with push in the same cycle -> count_o=0 next cycle, drop_count_o unchanged, out_valid_o=0.
REQ-040 drop_count preloaded by forcing 2^16 drops -> drop_count_o holds 16'hFFFF.
REQ-041 With TRACE_BUFFER_TIMESTAMP_EN, pushes at cycles 10 and 13 after reset -> out_timestamp_o reads 10 then 13.

Source files
------------

// File: rtl/trace_buffer_pkg.sv
// Shared types and defaults for the trace buffer.
// Optional feature: TRACE_BUFFER_TIMESTAMP_EN adds a 32-bit push timestamp to each entry.
package ryuki_datatypes;

    localparam int TRACE_BUFFER_DEPTH  = 16;
    localparam int TRACE_BUFFER_DROP_W = 16;

    // One record as produced by trace_unit.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } trace_output;

    // What the buffer actually stores per slot.
    typedef struct packed {
        trace_output rec;
        logic        gap;   // one or more records were dropped just before this one
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        logic [31:0] ts;    // cycle counter value when the record was pushed
`endif
    } trace_buffer_entry;

endpackage

// File: rtl/trace_buffer_fifo.sv
// trace_fifo: show-ahead pointer/storage core for trace_buffer.
// Strobes arrive pre-qualified: push_i only when there is room (or a pop in
// the same cycle), pop_i only when not empty. Flush and reset both return the
// pointers to zero; storage is never cleared.
module trace_fifo
    import ryuki_datatypes::*;
#(
    parameter type T     = trace_buffer_entry,
    parameter int  DEPTH = TRACE_BUFFER_DEPTH
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  T                       wdata_i,
    output T                       head_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    T            r_mem [DEPTH];

    assign empty_o = (r_wptr == r_rptr);
    assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign count_o = r_wptr - r_rptr;
    assign head_o  = r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset and flush both empty the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (push_i) r_wptr <= r_wptr + 1'b1;
            if (pop_i)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care until the pointers cover them.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wptr[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: lossy show-ahead buffer between trace_unit and its consumer.
// The tracer cannot be stalled, so pushes into a full buffer are dropped,
// counted (saturating) and flagged on the next stored entry as a gap.
// Optional feature: define TRACE_BUFFER_TIMESTAMP_EN to add out_timestamp_o
// and a free-running cycle counter sampled into every accepted entry.
module trace_buffer
    import ryuki_datatypes::*;
#(
    parameter int DEPTH  = TRACE_BUFFER_DEPTH,
    parameter int DROP_W = TRACE_BUFFER_DROP_W
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   trace_ready_i,
    input  trace_output            trace_i,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output trace_output            out_data_o,
    output logic                   out_gap_o,
    output logic [$clog2(DEPTH):0] count_o,
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    output logic [31:0]            out_timestamp_o,
`endif
    output logic [DROP_W-1:0]      drop_count_o
);

    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    trace_buffer_entry w_wr;
    trace_buffer_entry w_head;

    logic              r_gap_pending;
    logic [DROP_W-1:0] r_drop_count;

    // Flush wins over everything; a push that lands in a flush is simply lost
    // and is not a drop. A same-cycle pop frees the slot a full push needs.
    assign w_pop  = out_ready_i & ~w_empty & ~flush_i;
    assign w_push = trace_ready_i & (~w_full | w_pop) & ~flush_i;
    assign w_drop = trace_ready_i & w_full & ~w_pop & ~flush_i;

`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0] r_ts;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i) r_ts <= '0;
        else       r_ts <= r_ts + 32'd1;
    end

    // Entry assembly: record, pending gap flag and push-cycle timestamp.
    always_comb begin
        w_wr     = '0;
        w_wr.rec = trace_i;
        w_wr.gap = r_gap_pending;
        w_wr.ts  = r_ts;
    end

    assign out_timestamp_o = w_head.ts;
`else
    // Entry assembly: record plus pending gap flag.
    always_comb begin
        w_wr     = '0;
        w_wr.rec = trace_i;
        w_wr.gap = r_gap_pending;
    end
`endif

    trace_fifo #(
        .T     (trace_buffer_entry),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .wdata_i (w_wr),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (count_o)
    );

    // Gap tracking: set by a drop, consumed by the next stored entry.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) r_gap_pending <= 1'b0;
        else if (w_drop)      r_gap_pending <= 1'b1;
        else if (w_push)      r_gap_pending <= 1'b0;
    end

    // Drop counter, saturating; survives flush.
    always_ff @(posedge clk_i) begin
        if (rst_i)                              r_drop_count <= '0;
        else if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + DROP_W'(1);
    end

    assign out_valid_o  = ~w_empty;
    assign out_data_o   = w_head.rec;
    // Storage is not reset, so hide a stale gap bit while nothing is queued.
    assign out_gap_o    = w_head.gap & ~w_empty;
    assign drop_count_o = r_drop_count;

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer at DEPTH=4.
module tb_trace_buffer;
    import ryuki_datatypes::*;

    localparam int DEPTH  = 4;
    localparam int DROP_W = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        trace_ready = 1'b0;
    trace_output trace_d = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    trace_output out_data;
    logic        out_gap;
    logic [2:0]  count;
    logic [15:0] drop_count;
`ifdef TRACE_BUFFER_TIMESTAMP_EN
    logic [31:0] out_ts;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .trace_ready_i (trace_ready),
        .trace_i       (trace_d),
        .flush_i       (flush),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_data_o    (out_data),
        .out_gap_o     (out_gap),
        .count_o       (count),
`ifdef TRACE_BUFFER_TIMESTAMP_EN
        .out_timestamp_o (out_ts),
`endif
        .drop_count_o  (drop_count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic trace_output mk(input int i);
        trace_output r;
        r.pc   = 32'h0000_1000 + 32'(i);
        r.insn = 32'(i);
        return r;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; trace_ready = 1'b0; out_ready = 1'b0; flush = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic push(input int i);
        trace_ready = 1'b1; trace_d = mk(i);
        step();
        trace_ready = 1'b0;
    endtask

    task automatic pop_check(input string tag, input int i, input logic gap);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"}, 64'(out_data), 64'(mk(i)));
        check({tag, "_gap"}, 64'(out_gap), 64'(gap));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_gap", 64'(out_gap), 64'd0);

        // Single push, one-cycle latency
        push(0);
        check("one_valid", 64'(out_valid), 64'd1);
        check("one_data", 64'(out_data), 64'(mk(0)));
        check("one_count", 64'(count), 64'd1);
        check("one_gap", 64'(out_gap), 64'd0);
        // Head holds while not accepted
        step();
        check("hold_data", 64'(out_data), 64'(mk(0)));

        // Six pushes into four slots: two drops, gap flagged on next entry
        do_reset();
        for (int i = 0; i < 6; i++) push(i);
        check("ovf_count", 64'(count), 64'd4);
        check("ovf_drop", 64'(drop_count), 64'd2);
        for (int i = 0; i < 4; i++) pop_check("ovf_pop", i, 1'b0);
        check("ovf_empty", 64'(out_valid), 64'd0);
        push(6);
        pop_check("gap_G", 6, 1'b1);
        push(7);
        pop_check("gap_clr", 7, 1'b0);

        // Full with simultaneous push and pop
        do_reset();
        for (int i = 10; i < 14; i++) push(i);
        trace_ready = 1'b1; trace_d = mk(14); out_ready = 1'b1;
        step();
        trace_ready = 1'b0; out_ready = 1'b0;
        check("pp_count", 64'(count), 64'd4);
        check("pp_drop", 64'(drop_count), 64'd0);
        for (int i = 11; i < 15; i++) pop_check("pp_pop", i, 1'b0);

        // Flush with same-cycle push; pending gap is cleared, drops retained
        for (int i = 20; i < 25; i++) push(i);
        check("fl_pre_drop", 64'(drop_count), 64'd1);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        check("fl_pre_count", 64'(count), 64'd3);
        flush = 1'b1; trace_ready = 1'b1; trace_d = mk(25);
        step();
        flush = 1'b0; trace_ready = 1'b0;
        check("fl_count", 64'(count), 64'd0);
        check("fl_valid", 64'(out_valid), 64'd0);
        check("fl_drop", 64'(drop_count), 64'd1);
        push(26);
        check("fl_next_gap", 64'(out_gap), 64'd0);
        check("fl_next_data", 64'(out_data), 64'(mk(26)));

        // Reset mid-operation with push and pop in the reset cycle
        push(27);
        check("mr_pre_count", 64'(count), 64'd2);
        rst = 1'b1; trace_ready = 1'b1; trace_d = mk(28); out_ready = 1'b1;
        step();
        rst = 1'b0; trace_ready = 1'b0; out_ready = 1'b0;
        check("mr_count", 64'(count), 64'd0);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_drop", 64'(drop_count), 64'd0);
        step();
        check("mr_count2", 64'(count), 64'd0);

        // Pop request while empty is ignored
        out_ready = 1'b1;
        step();
        check("ep_count", 64'(count), 64'd0);
        trace_ready = 1'b1; trace_d = mk(30);
        step();
        trace_ready = 1'b0; out_ready = 1'b0;
        check("ep_valid", 64'(out_valid), 64'd1);
        check("ep_count1", 64'(count), 64'd1);
        check("ep_data", 64'(out_data), 64'(mk(30)));

        // Drop counter saturation
        do_reset();
        for (int i = 40; i < 44; i++) push(i);
        trace_ready = 1'b1; trace_d = mk(44);
        for (int i = 0; i < 65540; i++) step();
        trace_ready = 1'b0;
        check("sat_drop", 64'(drop_count), 64'hFFFF);
        check("sat_count", 64'(count), 64'd4);
        trace_ready = 1'b1; trace_d = mk(45); out_ready = 1'b1;
        step();
        trace_ready = 1'b0; out_ready = 1'b0;
        check("sat_pp_drop", 64'(drop_count), 64'hFFFF);
        check("sat_pp_count", 64'(count), 64'd4);
        pop_check("sat_head", 41, 1'b0);

`ifdef TRACE_BUFFER_TIMESTAMP_EN
        // Timestamps at cycles 10 and 13 after reset
        do_reset();
        repeat (10) step();
        push(50);
        step(); step();
        push(51);
        check("ts_first", 64'(out_ts), 64'd10);
        pop_check("ts_pop0", 50, 1'b0);
        check("ts_second", 64'(out_ts), 64'd13);
        pop_check("ts_pop1", 51, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
